// File: rtl/photodiode_pkg.sv
// Shared register map, event word layout and status field positions for the
// photodiode beam scanner.
package photodiode_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_EVENT   = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_CLEAR   = 2'd3;

  localparam int unsigned EV_VALID   = 31;
  localparam int unsigned EV_EDGE    = 8;
  localparam int unsigned EV_IDX_LSB = 0;

  localparam int unsigned ST_STABLE_LSB = 0;
  localparam int unsigned ST_EMPTY      = 16;
  localparam int unsigned ST_FULL       = 17;
  localparam int unsigned ST_OVERFLOW   = 18;
  localparam int unsigned ST_COUNT_LSB  = 24;

  function automatic logic [31:0] event_word(input logic brk, input logic [2:0] idx);
    logic [31:0] w;
    w                   = '0;
    w[EV_VALID]         = 1'b1;
    w[EV_EDGE]          = brk;
    w[EV_IDX_LSB +: 3]  = idx;
    return w;
  endfunction

endpackage

// File: rtl/beam_debouncer.sv
// One photodiode input: 2-FF synchroniser, hold-time debouncer and a one-cycle
// pulse whenever the accepted (stable) level changes.
module beam_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic beam_i,
  output logic stable_o,
  output logic pulse_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q, stable_q, pulse_q;
  logic [CntW-1:0] cnt_q;

  // Synchroniser resets to "beam present" so reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= beam_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
        pulse_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;
  assign pulse_o  = pulse_q;

endmodule

// File: rtl/photodiode_beam_scanner.sv
// Avalon-MM photodiode scanner: debounced beam edges are queued as events in a
// FIFO that software drains through the EVENT register, with a level IRQ.
module photodiode_beam_scanner
  import photodiode_pkg::*;
#(
  parameter int unsigned NUM_BEAMS       = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BEAMS-1:0] photodiode_in,
  input  logic [1:0]           avs_address,
  input  logic                 avs_read,
  output logic [31:0]          avs_readdata,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
  output logic                 irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]  stable_all, pulse_all;
  logic [7:0]  pend_q, pend_brk_q, pend_d, pend_brk_d, beam_mask_q;
  logic        irq_en_q, irq_q, overflow_q;
  logic [AW:0] wptr_q, rptr_q, count;
  logic [31:0] mem_q [FIFO_DEPTH];
  logic [31:0] rdata_q, rdata_d, status;
  logic        empty, full, pop, push, push_wr, drop, arb_brk, wr_ctrl, wr_clear;
  logic [2:0]  arb_idx;
  logic [4:0]  count5;
  logic        unused_wdata;

  for (genvar g = 0; g < 8; g++) begin : g_beam
    if (g < NUM_BEAMS) begin : g_used
      beam_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk_i   (clk),
        .reset_i (reset),
        .beam_i  (photodiode_in[g]),
        .stable_o(stable_all[g]),
        .pulse_o (pulse_all[g])
      );
    end else begin : g_unused
      assign stable_all[g] = 1'b1;
      assign pulse_all[g]  = 1'b0;
    end
  end

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count    = wptr_q - rptr_q;
  assign count5   = 5'(count);
  assign pop      = avs_read && (avs_address == REG_EVENT) && !empty;
  assign wr_ctrl  = avs_write && (avs_address == REG_CONTROL);
  assign wr_clear = avs_write && (avs_address == REG_CLEAR);
  assign unused_wdata = ^{avs_writedata[31:16], avs_writedata[7:2]};

  // Lowest pending beam wins; a fresh edge on that same beam re-arms its flag.
  always_comb begin
    push    = 1'b0;
    arb_idx = '0;
    arb_brk = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) begin
        push    = 1'b1;
        arb_idx = 3'(i);
        arb_brk = pend_brk_q[i];
      end
    end
    pend_d     = pend_q;
    pend_brk_d = pend_brk_q;
    if (push) pend_d[arb_idx] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pulse_all[i] && beam_mask_q[i]) begin
        pend_d[i]     = 1'b1;
        pend_brk_d[i] = ~stable_all[i];
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_wr = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    status                       = '0;
    status[ST_STABLE_LSB +: 8]   = stable_all;
    status[ST_EMPTY]             = empty;
    status[ST_FULL]              = full;
    status[ST_OVERFLOW]          = overflow_q;
    status[ST_COUNT_LSB +: 5]    = count5;
    rdata_d = '0;
    case (avs_address)
      REG_STATUS:  rdata_d = status;
      REG_EVENT:   rdata_d = empty ? '0 : mem_q[rptr_q[AW-1:0]];
      REG_CONTROL: rdata_d = {16'h0, beam_mask_q, 7'h0, irq_en_q};
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_wr) mem_q[wptr_q[AW-1:0]] <= event_word(arb_brk, arb_idx);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      pend_brk_q  <= '0;
      beam_mask_q <= '1;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      overflow_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rdata_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      pend_brk_q <= pend_brk_d;
      if (wr_ctrl) begin
        irq_en_q    <= avs_writedata[0];
        beam_mask_q <= avs_writedata[15:8];
      end
      if (wr_clear && avs_writedata[1]) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_wr) wptr_q <= wptr_q + 1'b1;
        if (pop)     rptr_q <= rptr_q + 1'b1;
      end
      if (drop) overflow_q <= 1'b1;
      else if (wr_clear && avs_writedata[0]) overflow_q <= 1'b0;
      irq_q   <= irq_en_q & ~empty;
      rdata_q <= avs_read ? rdata_d : '0;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_photodiode_beam_scanner.sv
// Directed bench for photodiode_beam_scanner with a short debounce window.
module tb_photodiode_beam_scanner;

  localparam int unsigned D = 8;

  logic        clk, reset;
  logic [7:0]  photodiode_in;
  logic [1:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_readdata, avs_writedata;
  logic        irq;
  logic [31:0] rd;
  int          n_cmp, n_err;

  photodiode_beam_scanner #(
    .NUM_BEAMS      (8),
    .DEBOUNCE_CYCLES(D),
    .FIFO_DEPTH     (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .photodiode_in(photodiode_in),
    .avs_address  (avs_address),
    .avs_read     (avs_read),
    .avs_readdata (avs_readdata),
    .avs_write    (avs_write),
    .avs_writedata(avs_writedata),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    avs_address = addr;
    avs_read    = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    data     = avs_readdata;
  endtask

  task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    photodiode_in = 8'hFF;
    avs_address = 2'd0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    avs_writedata = '0;
    wait_cycles(3);
    reset = 1'b0;

    // Reset state
    rd_reg(2'd0, rd); check("reset_status", rd, 32'h0001_00FF);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rd_reg(2'd2, rd); check("reset_control", rd, 32'h0000_FF00);
    rd_reg(2'd1, rd); check("reset_event_empty", rd, 32'h0);

    // Beam 3 break with IRQ enabled
    wr_reg(2'd2, 32'h0000_FF01);
    photodiode_in = 8'hF7;
    wait_cycles(D + 10);
    check("b3_irq_up", {31'h0, irq}, 32'h1);
    rd_reg(2'd0, rd); check("b3_status", rd, 32'h0100_00F7);
    rd_reg(2'd1, rd); check("b3_event", rd, 32'h8000_0103);
    check("b3_irq_hold", {31'h0, irq}, 32'h1);
    wait_cycles(1);
    check("b3_irq_down", {31'h0, irq}, 32'h0);
    rd_reg(2'd0, rd); check("b3_status_empty", rd, 32'h0001_00F7);

    // Glitch on beam 0 one cycle short of the debounce window
    photodiode_in = 8'hF6;
    wait_cycles(D - 1);
    photodiode_in = 8'hF7;
    wait_cycles(D + 10);
    rd_reg(2'd0, rd); check("glitch_status", rd, 32'h0001_00F7);
    check("glitch_irq", {31'h0, irq}, 32'h0);

    // Beams 1 and 5 break together, then restore together
    photodiode_in = 8'hD5;
    wait_cycles(D + 10);
    rd_reg(2'd1, rd); check("b15_break_first", rd, 32'h8000_0101);
    rd_reg(2'd1, rd); check("b15_break_second", rd, 32'h8000_0105);
    photodiode_in = 8'hF7;
    wait_cycles(D + 10);
    rd_reg(2'd1, rd); check("b15_restore_first", rd, 32'h8000_0001);
    rd_reg(2'd1, rd); check("b15_restore_second", rd, 32'h8000_0005);
    rd_reg(2'd1, rd); check("b15_drained", rd, 32'h0);

    // 17 events into a 16-deep FIFO
    photodiode_in = 8'h08;
    wait_cycles(D + 15);
    photodiode_in = 8'hF7;
    wait_cycles(D + 15);
    photodiode_in = 8'hF6;
    wait_cycles(D + 15);
    rd_reg(2'd0, rd); check("ovf_status", rd, 32'h1006_00F6);
    check("ovf_irq", {31'h0, irq}, 32'h1);
    rd_reg(2'd1, rd); check("ovf_head", rd, 32'h8000_0100);
    rd_reg(2'd0, rd); check("ovf_status_pop", rd, 32'h0F04_00F6);
    wr_reg(2'd3, 32'h0000_0003);
    rd_reg(2'd0, rd); check("clear_status", rd, 32'h0001_00F6);
    check("clear_irq", {31'h0, irq}, 32'h0);

    // Masked beam 0: level tracks but no event
    wr_reg(2'd2, 32'h0000_FE01);
    rd_reg(2'd2, rd); check("mask_control", rd, 32'h0000_FE01);
    photodiode_in = 8'hF7;
    wait_cycles(D + 10);
    rd_reg(2'd0, rd); check("mask_restore_status", rd, 32'h0001_00F7);
    photodiode_in = 8'hF6;
    wait_cycles(D + 10);
    rd_reg(2'd0, rd); check("mask_break_status", rd, 32'h0001_00F6);
    check("mask_irq", {31'h0, irq}, 32'h0);
    rd_reg(2'd1, rd); check("mask_event_none", rd, 32'h0);

    // Reset in the middle of a debounce
    wr_reg(2'd2, 32'h0000_FF01);
    photodiode_in = 8'h76;
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    rd_reg(2'd0, rd); check("midreset_status", rd, 32'h0001_00FF);
    rd_reg(2'd2, rd); check("midreset_control", rd, 32'h0000_FF00);
    check("midreset_irq", {31'h0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
